// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, XOR-checksummed
// byte image, writes 32-bit words, and holds the core in reset until it is verified.
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_cause
);

    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, RUN, ERR} state_t;

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t          state, state_nx;
    logic [15:0]     len;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_cnt;
    logic [23:0]     shreg;
    logic [7:0]      xor_acc;
    logic            take;
    logic            last_word;
    logic [16:0]     n_hdr;
    logic            in_final;

    assign take      = rx_valid && rx_ready;
    assign n_hdr     = {1'b0, rx_data, len[7:0]};
    assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};
    assign in_final  = (state == RUN) || (state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HDR_LO;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        unique case (state)
            HDR_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_nx = HDR_HI;
            end
            HDR_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (n_hdr > CAPACITY)  state_nx = ERR;
                    else if (n_hdr == '0)  state_nx = CSUM;
                    else                   state_nx = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && byte_cnt == 2'd3 && last_word) state_nx = CSUM;
            end
            CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_nx = (rx_data == xor_acc) ? RUN : ERR;
            end
            RUN: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (restart) state_nx = HDR_LO;
            end
            ERR: begin
                error = 1'b1;
                if (restart) state_nx = HDR_LO;
            end
            default: state_nx = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            xor_acc    <= '0;
            err_cause  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (take) begin
                if (state != CSUM) xor_acc <= xor_acc ^ rx_data;
                case (state)
                    HDR_LO: len[7:0] <= rx_data;
                    HDR_HI: begin
                        len[15:8] <= rx_data;
                        if (n_hdr > CAPACITY) err_cause <= 2'b01;
                    end
                    DATA: begin
                        // Bytes arrive LSB first, so shift in from the top.
                        byte_cnt <= byte_cnt + 2'd1;
                        shreg    <= {rx_data, shreg[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {rx_data, shreg};
                            word_cnt   <= word_cnt + 1'b1;
                        end
                    end
                    CSUM: if (rx_data != xor_acc) err_cause <= 2'b10;
                    default: ;
                endcase
            end else if (in_final && restart) begin
                len       <= '0;
                byte_cnt  <= '0;
                word_cnt  <= '0;
                shreg     <= '0;
                xor_acc   <= '0;
                err_cause <= '0;
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the instruction memory of the single-cycle RISC-V core from a byte stream and sequences the core's reset. It accepts a length-prefixed, XOR-checksummed image on a valid/ready byte interface, writes one 32-bit word per four bytes, and holds the core in reset until the whole image has been written and verified. It sits between the host link (UART receiver or test harness) and the instruction-memory write port, and drives the core's `reset` input.

## Interface

Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk` input, 1: system clock; one clock domain, all logic on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `rx_valid` input, 1: a byte is offered on `rx_data`.
- `rx_data` input, 8: offered byte.
- `rx_ready` output, 1: the loader accepts a byte this cycle. A byte transfers on `rx_valid && rx_ready`.
- `restart` input, 1: single-cycle request to reload; honoured only in RUN or ERR.
- `imem_we` output, 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output, ADDR_W: word address of the write.
- `imem_wdata` output, 32: word to write.
- `cpu_reset` output, 1: active-high reset to the core; high unless in RUN.
- `busy` output, 1: a load is in progress (HDR_LO through CSUM).
- `done` output, 1: image loaded and verified; the core is running.
- `error` output, 1: load failed.
- `err_cause` output, 2: 01 = length overflow, 10 = checksum mismatch, 00 = none.

## Operation

- Image format, little-endian: `N[7:0]`, `N[15:8]`, then N words of 4 bytes each (LSB first), then one checksum byte. The checksum byte equals the XOR of every preceding byte, header included.
- States: HDR_LO, HDR_HI, DATA, CSUM, RUN, ERR. Reset enters HDR_LO.
- HDR_LO: accept a byte into N[7:0], go to HDR_HI.
- HDR_HI: accept a byte into N[15:8].
  - If N > 2^ADDR_W, go to ERR with err_cause = 01.
  - Else if N == 0, go to CSUM.
  - Else go to DATA.
- DATA: collect bytes into a shift register using a 2-bit byte counter.
  - On the 4th byte, issue a word write and increment the word counter.
  - After the write of word N-1, go to CSUM.
- CSUM: accept one byte and compare it with the running XOR.
  - Equal: go to RUN.
  - Not equal: go to ERR with err_cause = 10.
- RUN: `cpu_reset` = 0 and `done` = 1. `restart` returns to HDR_LO.
- ERR: `cpu_reset` = 1 and `error` = 1. `restart` returns to HDR_LO.
- Leaving RUN or ERR via `restart` clears the XOR accumulator, both counters, N and err_cause. Instruction-memory contents are not cleared.
- `rx_ready` is a combinational decode of the state: 1 in HDR_LO, HDR_HI, DATA and CSUM; 0 in RUN and ERR. Bytes offered in RUN or ERR are not consumed.
- `restart` is ignored while `busy`.
- Word addresses run 0 to N-1. Since N ≤ 2^ADDR_W, the address never wraps.

## Timing

- Reset (asynchronous assert, synchronous deassert handled upstream) drives outputs to:
  - state = HDR_LO
  - `cpu_reset` = 1, `busy` = 1, `rx_ready` = 1
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0
  - `done` = 0, `error` = 0, `err_cause` = 00
- Throughput: one byte per cycle. Any gap in `rx_valid` stalls the loader with no loss of bytes.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th-byte handshake.
- Completion timing (all flags registered):
  - `cpu_reset` falls and `done` rises the cycle after the checksum-byte handshake.
  - On a checksum mismatch, `error` rises the cycle after that handshake.
  - On length overflow, `error` rises the cycle after the N[15:8] handshake.
- Restart timing: a `restart` sampled high in RUN makes `cpu_reset` = 1, `done` = 0 and `busy` = 1 on the next cycle. The same timing applies in ERR, with `error` and `err_cause` clearing.
- Reset mid-load aborts immediately. A partially written instruction memory is left as is, and the next image starts from the header.

## Test plan

- Load with ADDR_W=10: stream 02 00 93 00 50 00 13 00 00 00 D2 with no gaps.
  - Required: write of addr 0 = 0x00500093, then addr 1 = 0x00000013.
  - Required: `cpu_reset` falls and `done` rises 1 cycle after the D2 handshake.
- Backpressure: send the same stream with `rx_valid` low on alternate cycles. Required: identical writes, `done` set, no byte lost or duplicated.
- Checksum error: send the same stream with the last byte D3. Required: no `done`, `error` = 1, err_cause = 10, `cpu_reset` held at 1, `rx_ready` = 0.
- Length overflow: send 01 04 (N = 1025 > 1024). Required: error, err_cause = 01 one cycle after the second byte, zero writes.
- Empty image: send 00 00 00. Required: `done` with no `imem_we` pulse.
- Restart and reset mid-load:
  - Pulse `restart` in RUN. Required: `cpu_reset` = 1 the next cycle, and a new image reloads correctly.
  - Assert `reset` after 5 bytes. Required: all outputs at reset values immediately, and a full image loads afterwards.
